// File: rtl/ptw_sched_module.sv
// Sv32 page-table-walk scheduler: round-robin ITLB/DTLB arbitration, two-level
// walk over a shared single-outstanding read port, PTE checks and flush handling.
module ptw_sched_module #(
  parameter int VADDR_WIDTH = 32,
  parameter int PADDR_WIDTH = 34,
  parameter int PTE_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_itlb_req_vld,
  input  logic [VADDR_WIDTH-1:0] i_itlb_req_vaddr,
  output logic                   o_itlb_req_rdy,
  input  logic                   i_dtlb_req_vld,
  input  logic [VADDR_WIDTH-1:0] i_dtlb_req_vaddr,
  output logic                   o_dtlb_req_rdy,
  input  logic [31:0]            i_satp,
  input  logic                   i_flush,
  output logic                   o_mem_rden,
  output logic [PADDR_WIDTH-1:0] o_mem_paddr,
  input  logic                   i_mem_rdy,
  input  logic                   i_mem_rvld,
  input  logic [PTE_WIDTH-1:0]   i_mem_rdat,
  output logic                   o_itlb_rsp_vld,
  output logic                   o_dtlb_rsp_vld,
  output logic [PTE_WIDTH-1:0]   o_rsp_pte,
  output logic [PADDR_WIDTH-1:0] o_rsp_paddr,
  output logic                   o_rsp_superpage,
  output logic                   o_rsp_pf,
  output logic                   o_busy
);

  // IDLE arbitrate | L1_REQ/L0_REQ issue PTE read | L1_WAIT/L0_WAIT await PTE
  // RESP report to source | DRAIN absorb the read orphaned by a flush
  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_L1_REQ  = 7'b0000010,
    S_L1_WAIT = 7'b0000100,
    S_L0_REQ  = 7'b0001000,
    S_L0_WAIT = 7'b0010000,
    S_RESP    = 7'b0100000,
    S_DRAIN   = 7'b1000000
  } state_t;

  state_t                 state_q;
  logic [1:0]             arb_q;
  logic [VADDR_WIDTH-1:0] vaddr_q;
  logic                   src_dtlb_q;
  logic [21:0]            ppn_q;
  logic [PTE_WIDTH-1:0]   rsp_pte_q;
  logic [PADDR_WIDTH-1:0] rsp_paddr_q;
  logic                   rsp_sp_q;
  logic                   rsp_pf_q;

  logic                   idle;
  logic                   grant_i;
  logic                   grant_d;
  logic                   pte_fault;
  logic                   pte_leaf;
  logic                   pte_misalign;
  logic [PADDR_WIDTH-1:0] l1_addr;
  logic [PADDR_WIDTH-1:0] l0_addr;
  logic [PADDR_WIDTH-1:0] sp_paddr;
  logic [PADDR_WIDTH-1:0] pg_paddr;
  logic                   unused_satp;

  assign unused_satp = ^i_satp[31:22];

  assign idle    = (state_q == S_IDLE);
  assign grant_i = idle & ~i_flush & i_itlb_req_vld & (~i_dtlb_req_vld | arb_q[0]);
  assign grant_d = idle & ~i_flush & i_dtlb_req_vld & (~i_itlb_req_vld | arb_q[1]);

  assign pte_fault    = ~i_mem_rdat[0] | (~i_mem_rdat[1] & i_mem_rdat[2]);
  assign pte_leaf     = i_mem_rdat[1] | i_mem_rdat[3];
  assign pte_misalign = |i_mem_rdat[19:10];

  assign l1_addr  = PADDR_WIDTH'({i_satp[21:0], 12'h000}) + PADDR_WIDTH'({vaddr_q[31:22], 2'b00});
  assign l0_addr  = PADDR_WIDTH'({ppn_q, 12'h000}) + PADDR_WIDTH'({vaddr_q[21:12], 2'b00});
  assign sp_paddr = PADDR_WIDTH'({i_mem_rdat[31:20], vaddr_q[21:0]});
  assign pg_paddr = PADDR_WIDTH'({i_mem_rdat[31:10], vaddr_q[11:0]});

  assign o_itlb_req_rdy  = grant_i;
  assign o_dtlb_req_rdy  = grant_d;
  assign o_mem_rden      = (state_q == S_L1_REQ) | (state_q == S_L0_REQ);
  assign o_busy          = ~idle;
  // a flush landing in RESP kills the pulse; the state leaves RESP regardless
  assign o_itlb_rsp_vld  = (state_q == S_RESP) & ~src_dtlb_q & ~i_flush;
  assign o_dtlb_rsp_vld  = (state_q == S_RESP) & src_dtlb_q & ~i_flush;
  assign o_rsp_pte       = rsp_pte_q;
  assign o_rsp_paddr     = rsp_paddr_q;
  assign o_rsp_superpage = rsp_sp_q;
  assign o_rsp_pf        = rsp_pf_q;

  always_comb begin
    o_mem_paddr = '0;
    if (state_q == S_L1_REQ) begin
      o_mem_paddr = l1_addr;
    end else if (state_q == S_L0_REQ) begin
      o_mem_paddr = l0_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arb_q       <= 2'b01;
      vaddr_q     <= '0;
      src_dtlb_q  <= 1'b0;
      ppn_q       <= '0;
      rsp_pte_q   <= '0;
      rsp_paddr_q <= '0;
      rsp_sp_q    <= 1'b0;
      rsp_pf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_i | grant_d) begin
            state_q    <= S_L1_REQ;
            arb_q      <= grant_i ? 2'b10 : 2'b01;
            vaddr_q    <= grant_i ? i_itlb_req_vaddr : i_dtlb_req_vaddr;
            src_dtlb_q <= grant_d;
          end
        end
        S_L1_REQ, S_L0_REQ: begin
          if (i_flush) begin
            state_q <= i_mem_rdy ? S_DRAIN : S_IDLE;
          end else if (i_mem_rdy) begin
            state_q <= (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
          end
        end
        S_L1_WAIT: begin
          if (i_flush) begin
            state_q <= i_mem_rvld ? S_IDLE : S_DRAIN;
          end else if (i_mem_rvld) begin
            if (pte_fault || (pte_leaf && pte_misalign)) begin
              state_q     <= S_RESP;
              rsp_pte_q   <= '0;
              rsp_paddr_q <= '0;
              rsp_sp_q    <= 1'b0;
              rsp_pf_q    <= 1'b1;
            end else if (pte_leaf) begin
              state_q     <= S_RESP;
              rsp_pte_q   <= i_mem_rdat;
              rsp_paddr_q <= sp_paddr;
              rsp_sp_q    <= 1'b1;
              rsp_pf_q    <= 1'b0;
            end else begin
              state_q <= S_L0_REQ;
              ppn_q   <= i_mem_rdat[31:10];
            end
          end
        end
        S_L0_WAIT: begin
          if (i_flush) begin
            state_q <= i_mem_rvld ? S_IDLE : S_DRAIN;
          end else if (i_mem_rvld) begin
            state_q  <= S_RESP;
            rsp_sp_q <= 1'b0;
            if (pte_fault || !pte_leaf) begin
              rsp_pte_q   <= '0;
              rsp_paddr_q <= '0;
              rsp_pf_q    <= 1'b1;
            end else begin
              rsp_pte_q   <= i_mem_rdat;
              rsp_paddr_q <= pg_paddr;
              rsp_pf_q    <= 1'b0;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (i_mem_rvld) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_sched_module.sv
// Randomized bench for ptw_sched_module: bench acts as both TLBs and the memory,
// predicting grants, PTE addresses and responses from the Sv32 walk rules.
module tb_ptw_sched_module;

  localparam longint MASK34   = (longint'(1) << 34) - 1;
  localparam int     FL_NONE   = 0;
  localparam int     FL_L1REQ  = 1;
  localparam int     FL_L1WAIT = 2;
  localparam int     FL_L0REQ  = 3;
  localparam int     FL_L0WAIT = 4;
  localparam int     FL_RESP   = 5;
  localparam int     FL_IDLE   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_itlb_req_vld;
  logic [31:0] i_itlb_req_vaddr;
  logic        o_itlb_req_rdy;
  logic        i_dtlb_req_vld;
  logic [31:0] i_dtlb_req_vaddr;
  logic        o_dtlb_req_rdy;
  logic [31:0] i_satp;
  logic        i_flush;
  logic        o_mem_rden;
  logic [33:0] o_mem_paddr;
  logic        i_mem_rdy;
  logic        i_mem_rvld;
  logic [31:0] i_mem_rdat;
  logic        o_itlb_rsp_vld;
  logic        o_dtlb_rsp_vld;
  logic [31:0] o_rsp_pte;
  logic [33:0] o_rsp_paddr;
  logic        o_rsp_superpage;
  logic        o_rsp_pf;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  bit ptr_i = 1'b1;

  always #5 clk = ~clk;

  ptw_sched_module dut (
    .clk              (clk),
    .rst              (rst),
    .i_itlb_req_vld   (i_itlb_req_vld),
    .i_itlb_req_vaddr (i_itlb_req_vaddr),
    .o_itlb_req_rdy   (o_itlb_req_rdy),
    .i_dtlb_req_vld   (i_dtlb_req_vld),
    .i_dtlb_req_vaddr (i_dtlb_req_vaddr),
    .o_dtlb_req_rdy   (o_dtlb_req_rdy),
    .i_satp           (i_satp),
    .i_flush          (i_flush),
    .o_mem_rden       (o_mem_rden),
    .o_mem_paddr      (o_mem_paddr),
    .i_mem_rdy        (i_mem_rdy),
    .i_mem_rvld       (i_mem_rvld),
    .i_mem_rdat       (i_mem_rdat),
    .o_itlb_rsp_vld   (o_itlb_rsp_vld),
    .o_dtlb_rsp_vld   (o_dtlb_rsp_vld),
    .o_rsp_pte        (o_rsp_pte),
    .o_rsp_paddr      (o_rsp_paddr),
    .o_rsp_superpage  (o_rsp_superpage),
    .o_rsp_pf         (o_rsp_pf),
    .o_busy           (o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_pte(input int kind, input bit lvl1);
    logic [31:0] p;
    p = $urandom();
    case (kind)
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2: begin p[0] = 1'b1; p[1] = 1'b1; if (lvl1) p[19:10] = '0; end
      3: begin p[0] = 1'b1; p[3] = 1'b1; p[19:10] = 10'($urandom_range(1, 1023)); end
      default: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b0; p[3] = 1'b0; end
    endcase
    return p;
  endfunction

  // One walk from an IDLE cycle back to IDLE. fl_at >= 0 places the flush at that
  // cycle of the chosen phase and keeps the memory handshake out of that cycle.
  task automatic walk(input int req_pat, input logic [31:0] va_i, input logic [31:0] va_d,
                      input logic [21:0] ppn, input logic [31:0] pte1, input logic [31:0] pte0,
                      input int max_dly, input int l0_rdy_dly, input int fl_mode, input int fl_at);
    bit          win_i, sp, pf, fl_here;
    longint      va, a, pa, pte_e, p64;
    int          stop, rd, fk, wd, fj, dd;
    logic [31:0] pte;
    win_i = (req_pat == 1) || (req_pat == 3 && ptr_i);
    sp = 1'b0; pf = 1'b0; pa = 0; pte_e = 0; stop = 0;
    i_mem_rdy = 1'b0; i_mem_rvld = 1'b0; i_flush = 1'b0;
    i_itlb_req_vaddr = va_i;
    i_dtlb_req_vaddr = va_d;
    i_satp = {10'($urandom()), ppn};
    i_itlb_req_vld = req_pat[0];
    i_dtlb_req_vld = req_pat[1];
    #1;
    chk("idle_busy", o_busy, 0);
    if (fl_mode == FL_IDLE) begin
      i_flush = 1'b1;
      #1;
      chk("flush_idle_rdy", {o_itlb_req_rdy, o_dtlb_req_rdy}, 0);
      tick();
      i_flush = 1'b0;
      #1;
      chk("flush_idle_busy", o_busy, 0);
    end
    chk("grant_rdy_i", o_itlb_req_rdy, win_i);
    chk("grant_rdy_d", o_dtlb_req_rdy, !win_i);
    ptr_i = !win_i;
    va = longint'(win_i ? va_i : va_d);
    tick();
    if (win_i) i_itlb_req_vld = 1'b0;
    else i_dtlb_req_vld = 1'b0;
    a = (longint'(ppn) * 4096 + (va / (1 << 22)) * 4) & MASK34;

    for (int l = 1; l >= 0 && stop == 0; l--) begin
      rd = (l == 0 && l0_rdy_dly >= 0) ? l0_rdy_dly : int'($urandom_range(0, max_dly));
      fl_here = (l == 1 && fl_mode == FL_L1REQ) || (l == 0 && fl_mode == FL_L0REQ);
      if (fl_at >= 0) begin
        fk = fl_at;
        if (rd <= fk) rd = fk + 1;
      end else begin
        fk = $urandom_range(0, rd);
      end
      for (int k = 0; k <= rd && stop == 0; k++) begin
        i_mem_rdy  = (k == rd);
        i_mem_rvld = 1'($urandom_range(0, 1));
        i_flush    = fl_here && (k == fk);
        #1;
        chk("req_rden", o_mem_rden, 1);
        chk("req_paddr", o_mem_paddr, a);
        chk("req_rsp_quiet", {o_itlb_rsp_vld, o_dtlb_rsp_vld}, 0);
        chk("req_rdy_quiet", {o_itlb_req_rdy, o_dtlb_req_rdy}, 0);
        tick();
        if (i_flush) stop = (k == rd) ? 3 : 2;
      end
      i_mem_rdy = 1'b0; i_mem_rvld = 1'b0; i_flush = 1'b0;
      if (stop == 0) begin
        wd = $urandom_range(0, max_dly);
        fl_here = (l == 1 && fl_mode == FL_L1WAIT) || (l == 0 && fl_mode == FL_L0WAIT);
        if (fl_at >= 0) begin
          fj = fl_at;
          if (wd <= fj) wd = fj + 1;
        end else begin
          fj = $urandom_range(0, wd);
        end
        pte = (l == 1) ? pte1 : pte0;
        for (int j = 0; j <= wd && stop == 0; j++) begin
          i_mem_rvld = (j == wd);
          i_mem_rdat = (j == wd) ? pte : $urandom();
          i_mem_rdy  = 1'($urandom_range(0, 1));
          i_flush    = fl_here && (j == fj);
          #1;
          chk("wait_rden", o_mem_rden, 0);
          chk("wait_rsp_quiet", {o_itlb_rsp_vld, o_dtlb_rsp_vld}, 0);
          chk("wait_busy", o_busy, 1);
          tick();
          if (i_flush) stop = (j == wd) ? 2 : 3;
        end
        i_mem_rvld = 1'b0; i_mem_rdy = 1'b0; i_flush = 1'b0;
        if (stop == 0) begin
          p64 = longint'(pte);
          if (!pte[0] || (!pte[1] && pte[2])) begin
            pf = 1'b1; stop = 1;
          end else if (pte[1] || pte[3]) begin
            stop = 1;
            if (l == 1) begin
              if (((p64 / 1024) % 1024) != 0) begin
                pf = 1'b1;
              end else begin
                sp = 1'b1; pte_e = p64;
                pa = (p64 / (1 << 20)) * (1 << 22) + va % (1 << 22);
              end
            end else begin
              pte_e = p64;
              pa = (p64 / 1024) * 4096 + va % 4096;
            end
          end else if (l == 1) begin
            a = ((p64 / 1024) * 4096 + ((va / 4096) % 1024) * 4) & MASK34;
          end else begin
            pf = 1'b1; stop = 1;
          end
        end
      end
    end

    if (stop == 1) begin
      i_flush = (fl_mode == FL_RESP);
      #1;
      chk("rsp_vld_i", o_itlb_rsp_vld, win_i && fl_mode != FL_RESP);
      chk("rsp_vld_d", o_dtlb_rsp_vld, !win_i && fl_mode != FL_RESP);
      if (fl_mode != FL_RESP) begin
        chk("rsp_pte", o_rsp_pte, pte_e);
        chk("rsp_paddr", o_rsp_paddr, pa);
        chk("rsp_superpage", o_rsp_superpage, sp);
        chk("rsp_pf", o_rsp_pf, pf);
      end
      tick();
      i_flush = 1'b0;
    end else if (stop == 3) begin
      dd = $urandom_range(0, max_dly + 1);
      for (int j = 0; j <= dd; j++) begin
        i_mem_rvld = (j == dd);
        i_itlb_req_vld = 1'b1;
        i_dtlb_req_vld = 1'b1;
        i_flush = 1'($urandom_range(0, 1));
        #1;
        chk("drain_busy", o_busy, 1);
        chk("drain_no_grant", {o_itlb_req_rdy, o_dtlb_req_rdy}, 0);
        chk("drain_quiet", {o_mem_rden, o_itlb_rsp_vld, o_dtlb_rsp_vld}, 0);
        tick();
      end
      i_mem_rvld = 1'b0;
      i_flush = 1'b0;
    end
    i_itlb_req_vld = 1'b0;
    i_dtlb_req_vld = 1'b0;
  endtask

  initial begin
    int          k1, k0, fm;
    logic [31:0] p1, p0;
    rst = 1'b1;
    i_itlb_req_vld = 1'b0; i_itlb_req_vaddr = '0;
    i_dtlb_req_vld = 1'b0; i_dtlb_req_vaddr = '0;
    i_satp = '0; i_flush = 1'b0;
    i_mem_rdy = 1'b0; i_mem_rvld = 1'b0; i_mem_rdat = '0;
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_rden", o_mem_rden, 0);
    chk("rst_mem_paddr", o_mem_paddr, 0);
    chk("rst_rsp_vld", {o_itlb_rsp_vld, o_dtlb_rsp_vld}, 0);
    chk("rst_rsp_pte", o_rsp_pte, 0);
    chk("rst_rsp_paddr", o_rsp_paddr, 0);
    chk("rst_rsp_flags", {o_rsp_superpage, o_rsp_pf}, 0);
    chk("rst_rdy", {o_itlb_req_rdy, o_dtlb_req_rdy}, 0);
    rst = 1'b0;
    tick();

    // both requesters valid: grants must alternate I, D, I, D, I, D
    walk(3, 32'h0040_1234, 32'h1234_5678, 22'h10, 32'h0000_2001, 32'h0123_40CF, 0, -1, FL_NONE, -1);
    walk(3, 32'h0AB0_0000, 32'h0040_1234, 22'h10, 32'h2000_00CF, 32'h0, 0, -1, FL_NONE, -1);
    walk(3, 32'h0040_1234, 32'h0000_0000, 22'h10, 32'h2000_04CF, 32'h0, 0, -1, FL_NONE, -1);
    walk(3, 32'hFFFF_F000, 32'h0040_1234, 22'h10, 32'h0000_0000, 32'h0, 0, -1, FL_NONE, -1);
    walk(3, 32'h0040_1234, 32'h0000_0000, 22'h10, 32'h0000_0005, 32'h0, 0, -1, FL_NONE, -1);
    walk(3, 32'h0000_0000, 32'h0040_1234, 22'h10, 32'h0000_2001, 32'h0000_0001, 0, -1, FL_NONE, -1);
    // flush in L1_WAIT, late rvld drains, then the pending DTLB walk completes
    walk(3, 32'h0040_1234, 32'h0080_2345, 22'h10, 32'h0000_2001, 32'h0123_40CF, 1, -1, FL_L1WAIT, 0);
    walk(3, 32'h0040_1234, 32'h0080_2345, 22'h10, 32'h0000_2001, 32'h0123_40CF, 0, -1, FL_NONE, -1);
    // memory stalls in L0_REQ, then a flush there without the handshake
    walk(1, 32'h0040_1234, 32'h0, 22'h10, 32'h0000_2001, 32'h0123_40CF, 0, 5, FL_NONE, -1);
    walk(1, 32'h0040_1234, 32'h0, 22'h10, 32'h0000_2001, 32'h0123_40CF, 0, 5, FL_L0REQ, 0);
    walk(2, 32'h0, 32'h0040_1234, 22'h10, 32'h0000_2001, 32'h0123_40CF, 0, -1, FL_NONE, -1);

    for (int n = 0; n < 300; n++) begin
      k1 = $urandom_range(0, 6);
      if (k1 > 4) k1 = 4;
      k0 = $urandom_range(0, 4);
      if (k0 == 3) k0 = 2;
      p1 = gen_pte(k1, 1'b1);
      p0 = gen_pte(k0, 1'b0);
      fm = $urandom_range(0, 13);
      if (fm > FL_IDLE) fm = FL_NONE;
      walk(int'($urandom_range(1, 3)), $urandom(), $urandom(), 22'($urandom()), p1, p0,
           int'($urandom_range(0, 3)), -1, fm, -1);
    end

    #1;
    chk("final_idle", o_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
